// File: rtl/lane_bar_sprite_engine.sv
// Multi-lane bar-sprite pixel source: N_LANES positioned/coloured/animated bars drawn from
// one shared 2-bit bitmap RAM, lowest lane index wins, fixed 2-clock pixel latency.
`timescale 1ns/1ps
module lane_bar_sprite_engine #(
  parameter int              CD        = 16,
  parameter int              N_LANES   = 5,
  parameter int              H_SIZE    = 32,
  parameter int              V_SIZE    = 64,
  parameter int              ID_BITS   = 3,
  parameter int              N_FRAMES  = 8,
  parameter logic [CD-1:0]   KEY_COLOR = '0,
  localparam int             XB        = $clog2(H_SIZE),
  localparam int             YB        = $clog2(V_SIZE),
  localparam int             RAM_AW    = ID_BITS + YB + XB
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  input  logic                ram_we,
  input  logic [RAM_AW-1:0]   ram_addr,
  input  logic [1:0]          ram_pixel,
  input  logic                reg_we,
  input  logic [2:0]          reg_lane,
  input  logic [1:0]          reg_sel,
  input  logic [31:0]         reg_data,
  output logic [CD-1:0]       sprite_rgb,
  output logic                hit,
  output logic [2:0]          hit_lane,
  output logic [N_LANES-1:0]  ani_done
);

  localparam logic [ID_BITS-1:0] LAST_F = ID_BITS'(N_FRAMES - 1);
  localparam logic [ID_BITS-1:0] ONE_F  = ID_BITS'(1);
  localparam logic [CD-1:0]      BAR_DEF = CD'(16'h07E0);
  localparam logic [CD-1:0]      WHITE   = {CD{1'b1}};

  // Per-lane programmable state
  logic [10:0]         r_x0   [N_LANES];
  logic [10:0]         r_y0   [N_LANES];
  logic [1:0]          r_mode [N_LANES];
  logic [ID_BITS-1:0]  r_id   [N_LANES];
  logic [ID_BITS-1:0]  r_f    [N_LANES];
  logic [CD-1:0]       r_bar  [N_LANES];
  logic [CD-1:0]       r_hl   [N_LANES];
  logic [N_LANES-1:0]  r_en;
  logic [N_LANES-1:0]  r_done;
  logic [7:0]          r_div;
  logic [7:0]          r_divcnt;
  logic [10:0]         r_x_d;

  logic                w_frame_tick;
  logic                w_ani_tick;
  logic [N_LANES-1:0]  w_ctrl_wr;

  logic signed [11:0]  w_xr [N_LANES];
  logic signed [11:0]  w_yr [N_LANES];
  logic [N_LANES-1:0]  w_lane_hit;

  logic                w_any;
  logic [2:0]          w_win;
  logic [ID_BITS-1:0]  w_sid;
  logic [XB-1:0]       w_xo;
  logic [YB-1:0]       w_yo;
  logic [CD-1:0]       w_bar_s;
  logic [CD-1:0]       w_hl_s;

  logic                r_hit_p1;
  logic [2:0]          r_lane_p1;
  logic [RAM_AW-1:0]   r_addr_p1;
  logic [CD-1:0]       r_bar_p1;
  logic [CD-1:0]       r_hl_p1;

  logic [1:0]          r_mem [2**RAM_AW];
  logic [1:0]          r_code_p2;
  logic                r_hit_p2;
  logic [2:0]          r_lane_p2;
  logic [CD-1:0]       r_bar_p2;
  logic [CD-1:0]       r_hl_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < N_LANES; l++) begin
        r_x0[l]   <= '0;
        r_y0[l]   <= '0;
        r_mode[l] <= '0;
        r_id[l]   <= '0;
        r_bar[l]  <= BAR_DEF;
        r_hl[l]   <= WHITE;
      end
      r_en  <= '0;
      r_div <= 8'd9;
    end else begin
      // Lanes beyond N_LANES never match reg_lane, so such writes fall through
      for (int l = 0; l < N_LANES; l++) begin
        if (reg_we && reg_lane == 3'(l)) begin
          case (reg_sel)
            2'd0: begin
              r_x0[l] <= reg_data[10:0];
              r_y0[l] <= reg_data[26:16];
            end
            2'd1: begin
              r_en[l]   <= reg_data[15];
              r_mode[l] <= reg_data[13:12];
              r_id[l]   <= reg_data[ID_BITS-1:0];
            end
            2'd2: begin
              r_bar[l] <= reg_data[CD-1:0];
              r_hl[l]  <= reg_data[16+CD-1:16];
            end
            default: ;
          endcase
        end
      end
      if (reg_we && reg_sel == 2'd3)
        r_div <= reg_data[7:0];
    end
  end

  always_comb begin
    w_ctrl_wr = '0;
    for (int l = 0; l < N_LANES; l++)
      w_ctrl_wr[l] = reg_we && (reg_sel == 2'd1) && (reg_lane == 3'(l));
  end

  assign w_frame_tick = (r_x_d == 11'd0) && (x == 11'd1) && (y == 11'd0);
  assign w_ani_tick   = w_frame_tick && (r_divcnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_d    <= '0;
      r_divcnt <= '0;
      r_done   <= '0;
      for (int l = 0; l < N_LANES; l++)
        r_f[l] <= '0;
    end else begin
      r_x_d <= x;
      if (w_frame_tick)
        r_divcnt <= (r_divcnt >= r_div) ? 8'd0 : r_divcnt + 8'd1;
      // A ctrl write restarts the animation even on an ani_tick cycle
      for (int l = 0; l < N_LANES; l++) begin
        if (w_ctrl_wr[l]) begin
          r_f[l]    <= '0;
          r_done[l] <= 1'b0;
        end else if (w_ani_tick) begin
          case (r_mode[l])
            2'd1: r_f[l] <= (r_f[l] == LAST_F) ? '0 : r_f[l] + ONE_F;
            2'd2: begin
              if (r_f[l] != LAST_F) begin
                r_f[l] <= r_f[l] + ONE_F;
                if (r_f[l] + ONE_F == LAST_F)
                  r_done[l] <= 1'b1;
              end
            end
            default: r_f[l] <= '0;
          endcase
        end
      end
    end
  end

  // Zero-extended subtraction keeps origins near 2047 from wrapping onto small x,y
  always_comb begin
    w_lane_hit = '0;
    for (int l = 0; l < N_LANES; l++) begin
      w_xr[l] = $signed({1'b0, x} - {1'b0, r_x0[l]});
      w_yr[l] = $signed({1'b0, y} - {1'b0, r_y0[l]});
      w_lane_hit[l] = r_en[l] && (w_xr[l][11:XB] == '0) && (w_yr[l][11:YB] == '0);
    end
  end

  always_comb begin
    w_any   = 1'b0;
    w_win   = '0;
    w_sid   = '0;
    w_xo    = '0;
    w_yo    = '0;
    w_bar_s = '0;
    w_hl_s  = '0;
    for (int l = N_LANES - 1; l >= 0; l--) begin
      if (w_lane_hit[l]) begin
        w_any   = 1'b1;
        w_win   = 3'(l);
        w_sid   = (r_mode[l] == 2'd1 || r_mode[l] == 2'd2) ? r_f[l] : r_id[l];
        w_xo    = w_xr[l][XB-1:0];
        w_yo    = w_yr[l][YB-1:0];
        w_bar_s = r_bar[l];
        w_hl_s  = r_hl[l];
      end
    end
  end

  // S1: winning lane, bitmap address and colour snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_p1  <= 1'b0;
      r_lane_p1 <= '0;
      r_addr_p1 <= '0;
      r_bar_p1  <= '0;
      r_hl_p1   <= '0;
    end else begin
      r_hit_p1  <= w_any;
      r_lane_p1 <= w_win;
      r_addr_p1 <= {w_sid, w_yo, w_xo};
      r_bar_p1  <= w_bar_s;
      r_hl_p1   <= w_hl_s;
    end
  end

  // S2: synchronous bitmap read (old data on same-address write) plus delayed controls
  always_ff @(posedge clk) begin
    if (ram_we)
      r_mem[ram_addr] <= ram_pixel;
    r_code_p2 <= r_mem[r_addr_p1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_p2  <= 1'b0;
      r_lane_p2 <= '0;
      r_bar_p2  <= '0;
      r_hl_p2   <= '0;
    end else begin
      r_hit_p2  <= r_hit_p1;
      r_lane_p2 <= r_lane_p1;
      r_bar_p2  <= r_bar_p1;
      r_hl_p2   <= r_hl_p1;
    end
  end

  always_comb begin
    sprite_rgb = KEY_COLOR;
    if (r_hit_p2) begin
      case (r_code_p2)
        2'b01:   sprite_rgb = r_bar_p2;
        2'b10:   sprite_rgb = WHITE;
        2'b11:   sprite_rgb = r_hl_p2;
        default: sprite_rgb = KEY_COLOR;
      endcase
    end
  end

  assign hit      = r_hit_p2;
  assign hit_lane = r_lane_p2;
  assign ani_done = r_done;

endmodule

// File: tb/tb_lane_bar_sprite_engine.sv
// Directed bench for lane_bar_sprite_engine: reset, single lane, priority, loop and
// one-shot animation, edge origins, palette and mid-line reset.
`timescale 1ns/1ps
module tb_lane_bar_sprite_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        ram_we = 1'b0;
  logic [13:0] ram_addr = '0;
  logic [1:0]  ram_pixel = '0;
  logic        reg_we = 1'b0;
  logic [2:0]  reg_lane = '0;
  logic [1:0]  reg_sel = '0;
  logic [31:0] reg_data = '0;
  logic [15:0] sprite_rgb;
  logic        hit;
  logic [2:0]  hit_lane;
  logic [4:0]  ani_done;

  int checks = 0;
  int errors = 0;

  lane_bar_sprite_engine dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_pixel(ram_pixel),
    .reg_we(reg_we), .reg_lane(reg_lane), .reg_sel(reg_sel), .reg_data(reg_data),
    .sprite_rgb(sprite_rgb), .hit(hit), .hit_lane(hit_lane), .ani_done(ani_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wr_reg(input logic [2:0] l, input logic [1:0] s, input logic [31:0] d);
    reg_lane = l; reg_sel = s; reg_data = d; reg_we = 1'b1;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic wr_ram(input int f, input int row, input int col, input logic [1:0] c);
    ram_addr = 14'((f << 11) | (row << 5) | col); ram_pixel = c; ram_we = 1'b1;
    @(posedge clk); #1;
    ram_we = 1'b0;
  endtask

  task automatic pix(input int px, input int py);
    x = 11'(px); y = 11'(py);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic ftick();
    x = 11'd0; y = 11'd0;
    @(posedge clk); #1;
    x = 11'd1;
    @(posedge clk); #1;
    x = 11'd500; y = 11'd500;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sprite_rgb !== 16'h0000) begin errors++; $display("FAIL rst_rgb got=%h exp=0000", sprite_rgb); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%b exp=0", hit); end
    checks++; if (hit_lane !== 3'd0) begin errors++; $display("FAIL rst_lane got=%0d exp=0", hit_lane); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    pix(100, 50);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_post_hit got=%b exp=0", hit); end
    checks++; if (ani_done !== 5'd0) begin errors++; $display("FAIL rst_done got=%b exp=00000", ani_done); end
  endtask

  task automatic test_single_lane();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 32; c++)
        wr_ram(0, r, c, 2'b01);
    wr_reg(3'd0, 2'd0, 32'h0032_0064);
    wr_reg(3'd0, 2'd1, 32'h0000_8000);
    pix(99, 50);
    checks++; if (sprite_rgb !== 16'h0000 || hit !== 1'b0) begin errors++; $display("FAIL t2_left got=%h/%b exp=0000/0", sprite_rgb, hit); end
    x = 11'd100; y = 11'd50;
    @(posedge clk); #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL t2_lat1 got=%b exp=0", hit); end
    @(posedge clk); #1;
    checks++; if (hit !== 1'b1 || sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t2_origin got=%h/%b exp=07e0/1", sprite_rgb, hit); end
    checks++; if (hit_lane !== 3'd0) begin errors++; $display("FAIL t2_lane got=%0d exp=0", hit_lane); end
    pix(132, 50);
    checks++; if (sprite_rgb !== 16'h0000 || hit !== 1'b0) begin errors++; $display("FAIL t2_right got=%h/%b exp=0000/0", sprite_rgb, hit); end
    pix(131, 113);
    checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t2_corner got=%h exp=07e0", sprite_rgb); end
    pix(100, 114);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL t2_below got=%b exp=0", hit); end
  endtask

  task automatic test_overlap();
    wr_reg(3'd1, 2'd0, 32'h0046_00BE);
    wr_reg(3'd1, 2'd2, 32'h0000_1111);
    wr_reg(3'd1, 2'd1, 32'h0000_8000);
    wr_reg(3'd3, 2'd0, 32'h004B_00C3);
    wr_reg(3'd3, 2'd2, 32'h0000_3333);
    wr_reg(3'd3, 2'd1, 32'h0000_8000);
    pix(200, 80);
    checks++; if (hit_lane !== 3'd1 || sprite_rgb !== 16'h1111) begin errors++; $display("FAIL t3_prio got=%0d/%h exp=1/1111", hit_lane, sprite_rgb); end
    wr_reg(3'd1, 2'd1, 32'h0000_0000);
    pix(200, 80);
    checks++; if (hit_lane !== 3'd3 || sprite_rgb !== 16'h3333) begin errors++; $display("FAIL t3_lane3 got=%0d/%h exp=3/3333", hit_lane, sprite_rgb); end
  endtask

  task automatic test_loop_anim();
    int exp_f [6] = '{1, 1, 1, 2, 2, 2};
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        wr_ram(f, 0, c, (c == f) ? 2'b01 : 2'b00);
    wr_reg(3'd2, 2'd0, 32'h0064_012C);
    wr_reg(3'd0, 2'd3, 32'h0000_0000);
    wr_reg(3'd2, 2'd1, 32'h0000_9000);
    pix(300, 100);
    checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t4_f0 got=%h exp=07e0", sprite_rgb); end
    pix(301, 100);
    checks++; if (sprite_rgb !== 16'h0000 || hit !== 1'b1) begin errors++; $display("FAIL t4_f0_off got=%h/%b exp=0000/1", sprite_rgb, hit); end
    for (int k = 1; k <= 8; k++) begin
      ftick();
      pix(300 + (k % 8), 100);
      checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t4_div0_step%0d got=%h exp=07e0", k, sprite_rgb); end
    end
    wr_reg(3'd0, 2'd3, 32'h0000_0002);
    for (int k = 0; k < 6; k++) begin
      ftick();
      pix(300 + exp_f[k], 100);
      checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t4_div2_tick%0d got=%h exp=07e0", k + 1, sprite_rgb); end
    end
  endtask

  task automatic test_one_shot();
    int f;
    wr_reg(3'd0, 2'd3, 32'h0000_0000);
    wr_reg(3'd4, 2'd0, 32'h0064_0190);
    wr_reg(3'd4, 2'd1, 32'h0000_A000);
    checks++; if (ani_done !== 5'd0) begin errors++; $display("FAIL t5_done_init got=%b exp=00000", ani_done); end
    for (int k = 1; k <= 8; k++) begin
      ftick();
      f = (k > 7) ? 7 : k;
      pix(400 + f, 100);
      checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t5_step%0d got=%h exp=07e0", k, sprite_rgb); end
      checks++; if (ani_done !== ((k >= 7) ? 5'b10000 : 5'b00000)) begin errors++; $display("FAIL t5_done%0d got=%b exp=%b", k, ani_done, (k >= 7) ? 5'b10000 : 5'b00000); end
    end
    x = 11'd0; y = 11'd0;
    @(posedge clk); #1;
    x = 11'd1;
    reg_lane = 3'd4; reg_sel = 2'd1; reg_data = 32'h0000_A000; reg_we = 1'b1;
    @(posedge clk); #1;
    reg_we = 1'b0;
    checks++; if (ani_done !== 5'd0) begin errors++; $display("FAIL t5_rewrite_done got=%b exp=00000", ani_done); end
    pix(400, 100);
    checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t5_rewrite_f0 got=%h exp=07e0", sprite_rgb); end
    pix(303, 100);
    checks++; if (sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t5_tick_seen got=%h exp=07e0", sprite_rgb); end
    repeat (7) ftick();
    checks++; if (ani_done !== 5'b10000) begin errors++; $display("FAIL t5_done_again got=%b exp=10000", ani_done); end
  endtask

  task automatic test_edge_palette();
    wr_ram(0, 5, 5, 2'b10);
    wr_ram(0, 5, 6, 2'b11);
    wr_ram(0, 5, 7, 2'b00);
    pix(105, 55);
    checks++; if (sprite_rgb !== 16'hFFFF) begin errors++; $display("FAIL t6_code10 got=%h exp=ffff", sprite_rgb); end
    pix(106, 55);
    checks++; if (sprite_rgb !== 16'hFFFF) begin errors++; $display("FAIL t6_hl_default got=%h exp=ffff", sprite_rgb); end
    wr_reg(3'd0, 2'd2, 32'hABCD_07E0);
    pix(106, 55);
    checks++; if (sprite_rgb !== 16'hABCD) begin errors++; $display("FAIL t6_hl_prog got=%h exp=abcd", sprite_rgb); end
    pix(107, 55);
    checks++; if (sprite_rgb !== 16'h0000 || hit !== 1'b1) begin errors++; $display("FAIL t6_code00 got=%h/%b exp=0000/1", sprite_rgb, hit); end
    wr_reg(3'd0, 2'd0, 32'h0032_07F8);
    pix(5, 50);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL t6_nowrap got=%b exp=0", hit); end
    pix(2045, 51);
    checks++; if (hit !== 1'b1 || sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t6_high got=%b/%h exp=1/07e0", hit, sprite_rgb); end
    wr_reg(3'd5, 2'd1, 32'h0000_0000);
    pix(2045, 51);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL t6_bad_lane got=%b exp=1", hit); end
  endtask

  task automatic test_midline_reset();
    wr_reg(3'd0, 2'd0, 32'h0032_0064);
    pix(100, 50);
    checks++; if (hit !== 1'b1 || sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t1_pre got=%b/%h exp=1/07e0", hit, sprite_rgb); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (sprite_rgb !== 16'h0000 || hit !== 1'b0 || hit_lane !== 3'd0) begin errors++; $display("FAIL t1_async got=%h/%b/%0d exp=0000/0/0", sprite_rgb, hit, hit_lane); end
    checks++; if (ani_done !== 5'd0) begin errors++; $display("FAIL t1_done got=%b exp=00000", ani_done); end
    @(posedge clk); #1 reset_n = 1'b1;
    pix(100, 50);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL t1_en_cleared got=%b exp=0", hit); end
    wr_reg(3'd0, 2'd1, 32'h0000_8000);
    pix(0, 0);
    checks++; if (hit !== 1'b1 || sprite_rgb !== 16'h07E0) begin errors++; $display("FAIL t1_origin0 got=%b/%h exp=1/07e0", hit, sprite_rgb); end
    wr_reg(3'd0, 2'd0, 32'h0032_0064);
    pix(106, 55);
    checks++; if (sprite_rgb !== 16'hFFFF) begin errors++; $display("FAIL t1_hl_default got=%h exp=ffff", sprite_rgb); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_overlap();
    test_loop_anim();
    test_one_shot();
    test_edge_palette();
    test_midline_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
